// File: rtl/mem_lsu_if.sv
// Load/store bus: core request/response channel plus the single-port word memory port.
// The LSU takes the slave side; the core/memory environment takes the master side.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator: turns byte/half/word requests into word memory cycles,
// with sign/zero extension on loads and read-modify-write for sub-word stores.
module mem_lsu #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    mem_lsu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nx;
    logic        we_r, uns_r, err_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r, word_r, rdata_r;
    logic        take, req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_ext, merged;

    assign take = bus.req_valid && bus.req_ready;

    // Priority order only matters for readability; any hit is an error.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == 2'b11)                                  req_err = 1'b1;
        else if (bus.req_size == 2'b01 && bus.req_addr[0])         req_err = 1'b1;
        else if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
        else if (bus.req_addr >= 32'(MEM_BYTES))                    req_err = 1'b1;
    end

    // Lane extract for loads and lane merge for sub-word stores, both off the live read word.
    always_comb begin
        lane_b   = bus.mem_rdata[{addr_r[1:0], 3'b000} +: 8];
        lane_h   = bus.mem_rdata[{addr_r[1], 4'b0000} +: 16];
        lane_ext = bus.mem_rdata;
        merged   = bus.mem_rdata;
        case (size_r)
            2'b00: begin
                lane_ext = uns_r ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merged[{addr_r[1:0], 3'b000} +: 8] = wdata_r[7:0];
            end
            2'b01: begin
                lane_ext = uns_r ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
                merged[{addr_r[1], 4'b0000} +: 16] = wdata_r[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (take) begin
                if (req_err)                                  state_nx = RESP;
                else if (bus.req_we && bus.req_size == 2'b10) state_nx = WR;
                else                                          state_nx = RD;
            end
            RD:      state_nx = we_r ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            err_r   <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= '0;
            wdata_r <= '0;
            word_r  <= '0;
            rdata_r <= '0;
        end else begin
            if (take) begin
                we_r    <= bus.req_we;
                uns_r   <= bus.req_unsigned;
                err_r   <= req_err;
                size_r  <= bus.req_size;
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
                rdata_r <= '0;
            end
            if (state == RD) begin
                if (we_r) word_r  <= merged;
                else      rdata_r <= lane_ext;
            end
        end
    end

    // Every output is qualified with !rst so a reset cycle never leaks a write or a response.
    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.mem_we     = (state == WR) && !rst;
    assign bus.mem_addr   = ((state == RD || state == WR) && !rst) ? {addr_r[31:2], 2'b00} : '0;
    assign bus.mem_wdata  = ((state == WR) && !rst) ? ((size_r == 2'b10) ? wdata_r : word_r) : '0;
    assign bus.resp_valid = (state == RESP) && !rst;
    assign bus.resp_rdata = bus.resp_valid ? rdata_r : '0;
    assign bus.resp_err   = bus.resp_valid ? err_r : 1'b0;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, hand-written multi-cycle sequences,
// then random traffic checked against a word-array reference model.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_lsu_if bus();

    mem_lsu #(.MEM_BYTES(4096)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nwe;
    } vec_t;

    // Reference: behaviour straight from the access rules, on a plain word array.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err,
                                  output int lat, output int nwe);
        logic [31:0] word, v, mask;
        int sh;
        rd = 0; nwe = 0;
        err = (size == 3) || (size == 1 && addr % 2 != 0) ||
              (size == 2 && addr % 4 != 0) || (addr >= 4096);
        if (err) begin lat = 1; return; end
        word = ref_mem[addr / 4];
        sh   = int'(addr % 4) * 8;
        if (!we) begin
            lat = 2;
            if (size == 2) rd = word;
            else if (size == 0) begin
                v = (word >> sh) & 32'hFF;
                if (!uns && v >= 128) v = v | 32'hFFFFFF00;
                rd = v;
            end else begin
                v = (word >> sh) & 32'hFFFF;
                if (!uns && v >= 32768) v = v | 32'hFFFF0000;
                rd = v;
            end
        end else begin
            nwe = 1;
            if (size == 2) begin
                lat = 2;
                ref_mem[addr / 4] = wdata;
            end else begin
                lat  = 3;
                mask = (size == 0 ? 32'hFF : 32'hFFFF) << sh;
                ref_mem[addr / 4] = (word & ~mask) | ((wdata << sh) & mask);
            end
        end
    endfunction

    // Issue one request from a post-edge point; returns observed latency and response.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rd, output logic err,
                           output int nwe);
        int w;
        lat = -1; rd = 'x; err = 'x; nwe = 0;
        w = 0;
        while (!bus.req_ready && w < 20) begin @(posedge clk); #1; w++; end
        if (!bus.req_ready) return;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.mem_we) nwe++;
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; err = bus.resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_txn(input string tag, input vec_t v, input int lat,
                             input logic [31:0] rd, input logic err, input int nwe);
        chk({tag, "_lat"},   32'(lat), 32'(v.lat));
        chk({tag, "_rdata"}, rd, v.rd);
        chk({tag, "_err"},   {31'h0, err}, {31'h0, v.err});
        chk({tag, "_nwe"},   32'(nwe), 32'(v.nwe));
        if (v.addr < 4096) chk({tag, "_mem"}, mem[v.addr[11:2]], ref_mem[v.addr[11:2]]);
    endtask

    vec_t        vt [11];
    vec_t        rv;
    int          lat, nwe, seen;
    logic [31:0] rd;
    logic        err;

    initial begin
        for (int i = 0; i < 1024; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        mem[8'h20 >> 2] = 32'h11223344; ref_mem[8'h20 >> 2] = 32'h11223344;
        mem[8'h30 >> 2] = 32'h80FF7F01; ref_mem[8'h30 >> 2] = 32'h80FF7F01;
        mem[8'h40 >> 2] = 32'h55667788; ref_mem[8'h40 >> 2] = 32'h55667788;

        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;

        //            we    size   uns   addr        wdata          rdata          err  lat nwe
        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
        vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h22,   32'hAA,       32'h0,        1'b0, 3, 1};
        vt[3]  = '{1'b0, 2'b00, 1'b0, 32'h33,   32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
        vt[4]  = '{1'b0, 2'b00, 1'b1, 32'h33,   32'h0,        32'h00000080, 1'b0, 2, 0};
        vt[5]  = '{1'b0, 2'b01, 1'b0, 32'h30,   32'h0,        32'h00007F01, 1'b0, 2, 0};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h32,   32'h0,        32'hFFFF80FF, 1'b0, 2, 0};
        vt[7]  = '{1'b0, 2'b10, 1'b0, 32'h02,   32'h0,        32'h0,        1'b1, 1, 0};
        vt[8]  = '{1'b1, 2'b01, 1'b0, 32'h05,   32'h1234,     32'h0,        1'b1, 1, 0};
        vt[9]  = '{1'b0, 2'b11, 1'b0, 32'h40,   32'h0,        32'h0,        1'b1, 1, 0};
        vt[10] = '{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, 1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        rst = 1'b0;
        #1;
        chk("idle_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            model(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, err, lat, nwe);
            run_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, lat, rd, err, nwe);
            check_txn($sformatf("vec%0d", i), vt[i], lat, rd, err, nwe);
        end
        chk("byte_merge_word", mem[8'h20 >> 2], 32'h11AA3344);

        // Back-to-back: req_valid held high across two loads
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h10;
        chk("b2b_ready_c0", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk); #1;
        bus.req_addr = 32'h30;
        chk("b2b_ready_c1", {31'h0, bus.req_ready}, 32'h0);
        @(posedge clk); #1;
        chk("b2b_ready_c2", {31'h0, bus.req_ready}, 32'h0);
        chk("b2b_resp1", {31'h0, bus.resp_valid}, 32'h1);
        chk("b2b_rdata1", bus.resp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("b2b_ready_c3", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("b2b_ready_c4", {31'h0, bus.req_ready}, 32'h0);
        @(posedge clk); #1;
        chk("b2b_resp2", {31'h0, bus.resp_valid}, 32'h1);
        chk("b2b_rdata2", bus.resp_rdata, 32'h80FF7F01);
        @(posedge clk); #1;

        // Reset in the WR cycle of a half store to 0x40
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
        bus.req_addr = 32'h40; bus.req_wdata = 32'hBEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rstwr_rd_cycle_we", {31'h0, bus.mem_we}, 32'h0);
        @(posedge clk); #1;
        chk("rstwr_wr_cycle_we", {31'h0, bus.mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rstwr_we_gated", {31'h0, bus.mem_we}, 32'h0);
        seen = 0;
        @(posedge clk); #1;
        if (bus.resp_valid) seen++;
        rst = 1'b0;
        #1;
        chk("rstwr_ready_after", {31'h0, bus.req_ready}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            if (bus.resp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rstwr_no_resp", 32'(seen), 32'h0);
        chk("rstwr_mem_kept", mem[8'h40 >> 2], 32'h55667788);

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            rv.we    = 1'($urandom_range(0, 1));
            rv.size  = 2'($urandom_range(0, 3));
            rv.uns   = 1'($urandom_range(0, 1));
            rv.addr  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(4090, 4200))
                                                     : 32'($urandom_range(0, 127));
            rv.wdata = $urandom;
            model(rv.we, rv.size, rv.uns, rv.addr, rv.wdata, rv.rd, rv.err, rv.lat, rv.nwe);
            run_req(rv.we, rv.size, rv.uns, rv.addr, rv.wdata, lat, rd, err, nwe);
            check_txn($sformatf("rnd%0d", i), rv, lat, rd, err, nwe);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator that sits between the core's execute stage and the single-port word memory.
- The memory has combinational read (indexed by addr[11:2]) and word-only writes at posedge clk.
- This block turns byte/halfword/word requests into memory cycles: read, extract, sign/zero-extend for loads; read-modify-write for sub-word stores.
- It flags misaligned, illegal-size and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 4096, memory size in bytes; req_addr >= MEM_BYTES is an access error.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned, illegal size or out of range.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address, always word-aligned.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word (combinational from mem_addr).

Behaviour:
- Handshake: transfer when req_valid && req_ready. Only one request in flight. No response backpressure.
- Request fields are latched into internal registers on transfer.
- FSM states: IDLE, RD, WR, RESP. Reset state is IDLE.
- IDLE: req_ready = !rst. On transfer:
  - error -> RESP
  - load -> RD
  - word store -> WR
  - byte/half store -> RD
- Error condition, in priority order: size==11, or half with addr[0]!=0, or word with addr[1:0]!=0, or addr >= MEM_BYTES.
- RD: mem_addr = {addr[31:2],2'b00}, mem_we = 0. Capture mem_rdata at posedge.
  - Load: extract lane, extend, go to RESP.
  - Store: merge data into captured word, go to WR.
- WR: mem_we = !rst, for exactly one cycle. mem_addr = word address. mem_wdata = merged word (sub-word) or req_wdata (word). Go to RESP.
- RESP: resp_valid = !rst, held for one cycle. Go to IDLE; req_ready returns the following cycle.
- Lane rules (little-endian):
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
  - Load byte/half: extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
  - Store merge: replace only the addressed lane with req_wdata[7:0] or [15:0]; all other bits are kept from the captured read.
- Latency, with the accept edge in cycle N:
  - Error: resp_valid in N+1.
  - Load: resp_valid in N+2.
  - Word store: mem_we in N+1, resp_valid in N+2.
  - Sub-word store: RD in N+1, mem_we in N+2, resp_valid in N+3.
- Idle values:
  - mem_addr = 0, mem_wdata = 0 outside RD/WR (mem_wdata = 0 except in WR).
  - resp_rdata and resp_err hold 0 except during RESP.
- Reset values: req_ready 0 while rst is high, otherwise IDLE default. mem_we 0, resp_valid 0, resp_rdata 0, resp_err 0, mem_addr 0, mem_wdata 0; all latched registers 0.
- Reset mid-operation: rst high in any state forces mem_we = 0 and resp_valid = 0 in that cycle. FSM returns to IDLE at the edge. No partial write ever reaches memory; the in-flight request is dropped with no response.
- req_valid outside IDLE is ignored; req_ready = 0.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> mem_we high exactly one cycle with mem_addr 0x10; load resp_rdata 0xDEADBEEF, resp_err 0, resp_valid at N+2.
- Memory word 0x11223344 at 0x20; byte store addr 0x22, data 0xAA -> memory becomes 0x11AA3344; resp_valid at N+3.
- Memory word 0x80FF7F01 at 0x30:
  - signed byte load 0x33 -> 0xFFFFFF80
  - unsigned byte load 0x33 -> 0x00000080
  - signed half load 0x30 -> 0x00007F01
  - signed half load 0x32 -> 0xFFFF80FF
- Error cases:
  - word load 0x02 -> resp_err 1, resp_rdata 0, resp_valid at N+1, mem_we never asserted.
  - half store 0x05 -> same error response.
  - size 11 -> same error response.
  - word load 0x1000 with MEM_BYTES 4096 -> same error response.
- Back-to-back: hold req_valid high with two loads queued -> second is accepted only in the cycle after RESP; req_ready is 0 for the whole busy period.
- Assert rst in the WR cycle of a half store to 0x40 (old value 0x55667788) -> mem_we stays 0, memory still 0x55667788, no resp_valid, req_ready 1 the cycle after rst drops.
